// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the pe_arbiter3 three-requester arbiter.
package pe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam logic [1:0] ID_NONE = 2'b00;
  localparam logic [1:0] ID_R0   = 2'b01;
  localparam logic [1:0] ID_R1   = 2'b10;
  localparam logic [1:0] ID_R2   = 2'b11;

  localparam int CNT_W = 8;

  function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
    logic [2:0] oh;
    case (id)
      ID_R0:   oh = 3'b001;
      ID_R1:   oh = 3'b010;
      ID_R2:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Requester index seen at encoder bit j when the search starts at ptr+1.
  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int j);
    int t;
    t = (int'(ptr) + 3 - j) % 3;
    return 2'(t);
  endfunction

endpackage

// File: rtl/pe_enc3.sv
// Combinational 3-to-2 priority encoder; bit 2 has the highest priority.
module pe_enc3
  import pe_arb_pkg::*;
(
  input  logic [2:0] req,
  output logic [1:0] id
);

  always_comb begin
    id = ID_NONE;
    if (req[2])      id = ID_R2;
    else if (req[1]) id = ID_R1;
    else if (req[0]) id = ID_R0;
  end

endmodule

// File: rtl/pe_arbiter3.sv
// Three-requester arbiter with hold limit and one-cycle turnaround gap.
// Define PE_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module pe_arbiter3
  import pe_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] rel,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [2:0]       gnt_reg, gnt_next;
  logic [1:0]       gnt_id_reg, gnt_id_next;
  logic             busy_reg, busy_next;
  logic             timeout_reg, timeout_next;

  logic [2:0] enc_in;
  logic [1:0] enc_id;
  logic [1:0] win_id;

`ifdef PE_ARB_ROUND_ROBIN_EN
  // Rotate so the requester after the last owner lands on encoder bit 2.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rot
    assign enc_in[gi] = req[rr_idx(ptr_reg, gi)];
  end

  always_comb begin
    win_id = ID_NONE;
    if (enc_id != ID_NONE)
      win_id = rr_idx(ptr_reg, int'(enc_id) - 1) + 2'd1;
  end
`else
  assign enc_in = req;
  assign win_id = enc_id;
`endif

  pe_enc3 u_enc (
    .req (enc_in),
    .id  (enc_id)
  );

  logic owner_rel, owner_drop, at_max;
  assign owner_rel  = |(gnt_reg & rel);
  assign owner_drop = ~|(gnt_reg & req);
  assign at_max     = (cnt_reg == HOLD_MAX_C);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    gnt_next     = 3'b000;
    gnt_id_next  = ID_NONE;
    busy_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_id != ID_NONE) begin
          state_next  = GRANT;
          cnt_next    = CNT_W'(1);
          ptr_next    = win_id - 2'd1;
          gnt_next    = id_to_onehot(win_id);
          gnt_id_next = win_id;
          busy_next   = 1'b1;
        end
      end
      GRANT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (owner_rel || owner_drop || at_max) begin
          state_next   = GAP;
          // A coincident release or dropped request wins over the hold limit.
          timeout_next = at_max && !owner_rel && !owner_drop;
        end else begin
          gnt_next    = gnt_reg;
          gnt_id_next = gnt_id_reg;
          busy_next   = 1'b1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ptr_reg     <= 2'd2;
      gnt_reg     <= 3'b000;
      gnt_id_reg  <= ID_NONE;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = gnt_id_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule
